// File: rtl/lz77_pkg.sv
// Shared types and default sizing for the LZ77 job controller and its bit packer.
package lz77_pkg;

  localparam int unsigned AddrBitsDefault       = 18;
  localparam int unsigned LenBitsDefault        = 18;
  localparam int unsigned WatchdogCyclesDefault = 1048575;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StFetch,
    StCapture,
    StFeed,
    StDrain,
    StFlush,
    StReport
  } state_e;

endpackage

// File: rtl/lz77_bit_packer.sv
// Packs the compressor's serial output bits MSB-first into bytes, with a zero-padded flush.
module lz77_bit_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bitIn,
  input  logic       bitValid,
  input  logic       flush,
  input  logic       outByteReady,
  output logic       compOutputReady,
  output logic [7:0] outByte,
  output logic       outByteValid
);

  logic [7:0] shiftReg, shiftNext, merged, byteNext;
  logic [2:0] bitCount, countNext;
  logic       partialEmpty, accept, validNext;

  assign partialEmpty = (bitCount == 3'd0);
  assign accept       = bitValid && compOutputReady;

  always_comb begin
    merged = shiftReg;
    if (accept) merged[3'd7 - bitCount] = bitIn;
    validNext = outByteValid && !outByteReady;
    byteNext  = outByte;
    shiftNext = shiftReg;
    countNext = bitCount;
    if ((accept && bitCount == 3'd7) ||
        (flush && !outByteValid && (accept || !partialEmpty))) begin
      byteNext  = merged;
      validNext = 1'b1;
      shiftNext = '0;
      countNext = '0;
    end else if (accept) begin
      shiftNext = merged;
      countNext = bitCount + 3'd1;
    end
  end

  // Ready is registered from the next valid so it reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg        <= '0;
      bitCount        <= '0;
      outByte         <= '0;
      outByteValid    <= 1'b0;
      compOutputReady <= 1'b0;
    end else begin
      shiftReg        <= shiftNext;
      bitCount        <= countNext;
      outByte         <= byteNext;
      outByteValid    <= validNext;
      compOutputReady <= !validNext;
    end
  end

endmodule

// File: rtl/lz77_job_controller.sv
// Runs one lz77_compressor through whole jobs: fetch source bytes, feed, pack output, report.
module lz77_job_controller
  import lz77_pkg::*;
#(
  parameter int unsigned addrBits       = AddrBitsDefault,
  parameter int unsigned lenBits        = LenBitsDefault,
  parameter int unsigned watchdogCycles = WatchdogCyclesDefault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmdValid,
  output logic                cmdReady,
  input  logic [addrBits-1:0] cmdBase,
  input  logic [lenBits-1:0]  cmdLength,
  output logic                memReadEn,
  output logic [addrBits-1:0] memAddr,
  input  logic [7:0]          memReadData,
  output logic                compStart,
  input  logic                compBusy,
  input  logic                compDone,
  output logic [7:0]          compInputData,
  output logic                compInputValid,
  input  logic                compInputReady,
  output logic                compLastInput,
  input  logic                compOutputBit,
  input  logic                compOutputValid,
  output logic                compOutputReady,
  input  logic [31:0]         compBytesRead,
  output logic [7:0]          outByte,
  output logic                outByteValid,
  input  logic                outByteReady,
  output logic                statusValid,
  output logic                statusError,
  output logic [31:0]         statusBits,
  output logic [31:0]         statusCycles
);

  localparam logic [lenBits-1:0] LenOne = lenBits'(1);

  state_e              state;
  logic [addrBits-1:0] base;
  logic [lenBits-1:0]  length, index;
  logic [31:0]         cycleCount, bitTotal, cycleSat;
  logic [32:0]         cycleInc;
  logic                wdExpired, wdHit, inJob, bitAccept, flushReq;

  assign cycleInc  = {1'b0, cycleCount} + 33'd1;
  assign cycleSat  = cycleInc[32] ? cycleCount : cycleInc[31:0];
  assign wdHit     = cycleInc >= 33'(watchdogCycles);
  assign inJob     = state inside {StStart, StWaitBusy, StFetch, StCapture, StFeed, StDrain};
  assign bitAccept = compOutputValid && compOutputReady;
  assign flushReq  = (state == StFlush) && !outByteValid;

  lz77_bit_packer u_packer (
    .clk            (clk),
    .rst_n          (rst_n),
    .bitIn          (compOutputBit),
    .bitValid       (compOutputValid),
    .flush          (flushReq),
    .outByteReady   (outByteReady),
    .compOutputReady(compOutputReady),
    .outByte        (outByte),
    .outByteValid   (outByteValid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      base           <= '0;
      length         <= '0;
      index          <= '0;
      cycleCount     <= '0;
      bitTotal       <= '0;
      wdExpired      <= 1'b0;
      cmdReady       <= 1'b1;
      memReadEn      <= 1'b0;
      memAddr        <= '0;
      compStart      <= 1'b0;
      compInputData  <= '0;
      compInputValid <= 1'b0;
      compLastInput  <= 1'b0;
      statusValid    <= 1'b0;
      statusError    <= 1'b0;
      statusBits     <= '0;
      statusCycles   <= '0;
    end else begin
      compStart   <= 1'b0;
      statusValid <= 1'b0;
      memReadEn   <= 1'b0;
      if (bitAccept && !(&bitTotal)) bitTotal <= bitTotal + 32'd1;
      if (inJob) cycleCount <= cycleSat;
      // Watchdog wins over every in-job state except the cycle done is seen.
      if (inJob && wdHit && !(state == StDrain && compDone)) begin
        state          <= StReport;
        wdExpired      <= 1'b1;
        compInputValid <= 1'b0;
        compLastInput  <= 1'b0;
      end else begin
        case (state)
          StIdle: if (cmdValid) begin
            base       <= cmdBase;
            length     <= cmdLength;
            index      <= '0;
            cycleCount <= '0;
            bitTotal   <= '0;
            wdExpired  <= 1'b0;
            cmdReady   <= 1'b0;
            if (cmdLength == '0) begin
              state <= StReport;
            end else begin
              compStart <= 1'b1;
              state     <= StStart;
            end
          end
          StStart: state <= StWaitBusy;
          StWaitBusy: if (compBusy) begin
            memReadEn <= 1'b1;
            memAddr   <= base;
            state     <= StFetch;
          end
          StFetch: state <= StCapture;
          StCapture: begin
            compInputData  <= memReadData;
            compInputValid <= 1'b1;
            compLastInput  <= (index == length - LenOne);
            state          <= StFeed;
          end
          StFeed: if (compInputReady) begin
            compInputValid <= 1'b0;
            compLastInput  <= 1'b0;
            if (compLastInput) begin
              state <= StDrain;
            end else begin
              index     <= index + LenOne;
              memReadEn <= 1'b1;
              memAddr   <= base + addrBits'(index + LenOne);
              state     <= StFetch;
            end
          end
          StDrain: if (compDone) state <= StFlush;
          StFlush: if (!outByteValid) state <= StReport;
          StReport: begin
            statusValid  <= 1'b1;
            statusError  <= (length == '0) || wdExpired || (compBytesRead != 32'(length));
            statusBits   <= bitTotal;
            statusCycles <= cycleCount;
            cmdReady     <= 1'b1;
            state        <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lz77_job_controller.sv
// Self-checking bench: job table plus random jobs against a behavioural compressor/memory model.
module tb_lz77_job_controller;

  localparam int AB = 18;
  localparam int LB = 18;
  localparam int WD = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmdValid, cmdReady;
  logic [AB-1:0] cmdBase;
  logic [LB-1:0] cmdLength;
  logic          memReadEn;
  logic [AB-1:0] memAddr;
  logic [7:0]    memReadData;
  logic          compStart, compBusy, compDone;
  logic [7:0]    compInputData;
  logic          compInputValid, compInputReady, compLastInput;
  logic          compOutputBit, compOutputValid, compOutputReady;
  logic [31:0]   compBytesRead;
  logic [7:0]    outByte;
  logic          outByteValid, outByteReady;
  logic          statusValid, statusError;
  logic [31:0]   statusBits, statusCycles;

  always #5 clk = ~clk;

  lz77_job_controller #(.addrBits(AB), .lenBits(LB), .watchdogCycles(WD)) dut (
    .clk(clk), .rst_n(rst_n), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdBase(cmdBase),
    .cmdLength(cmdLength), .memReadEn(memReadEn), .memAddr(memAddr), .memReadData(memReadData),
    .compStart(compStart), .compBusy(compBusy), .compDone(compDone),
    .compInputData(compInputData), .compInputValid(compInputValid),
    .compInputReady(compInputReady), .compLastInput(compLastInput),
    .compOutputBit(compOutputBit), .compOutputValid(compOutputValid),
    .compOutputReady(compOutputReady), .compBytesRead(compBytesRead), .outByte(outByte),
    .outByteValid(outByteValid), .outByteReady(outByteReady), .statusValid(statusValid),
    .statusError(statusError), .statusBits(statusBits), .statusCycles(statusCycles)
  );

  typedef struct {
    logic [AB-1:0] base;
    int len, readyPct, outReadyPct, outHold, bitsMax, preloadN;
    bit neverDone;
    int skew;
    bit expErr, preset41;
  } job_t;

  int compared = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory and compressor model state.
  logic [7:0]    mem [0:(1<<AB)-1];
  logic          rdPending;
  logic [AB-1:0] rdAddr;
  bit            bitQ[$], sentBits[$];
  logic [7:0]    consumed[$], outBytesQ[$], refBytes[$];
  int jobLen, readyPct, outReadyPct, holdCnt, bitsMax, preloadN, skew;
  bit neverDone, modelActive, inputDone, doneCaptured, holdSeen;
  int busyDelay, cyc, cycAtDone, startPulses, lastErr, nb;
  bit bv;
  logic holdEndReady, holdEndValid;
  logic [7:0] holdEndByte;
  logic prevValid, prevReady, prevLast;
  logic [7:0] prevData;

  always @(negedge clk) begin
    if (!rst_n) begin
      modelActive = 0; compBusy = 0; compDone = 0; compInputReady = 0; compOutputValid = 0;
      compOutputBit = 0; outByteReady = 0; rdPending = 0; prevValid = 0; bitQ.delete();
    end else begin
      memReadData = rdPending ? mem[rdAddr] : 8'($urandom);
      rdPending = memReadEn;
      rdAddr = memAddr;
      if (compStart) begin
        startPulses++; modelActive = 1; busyDelay = 2; inputDone = 0; doneCaptured = 0;
        cyc = 0; compBusy = 0; consumed.delete(); bitQ.delete();
        for (int i = 0; i < preloadN; i++) bitQ.push_back(~i[0]);
        sentBits = bitQ;
      end
      if (modelActive && !doneCaptured) cyc++;
      if (modelActive && busyDelay > 0) begin
        busyDelay--;
        if (busyDelay == 0) compBusy = 1;
      end
      if (prevValid && !prevReady)
        check("inputHeld", {compInputValid, compInputData, compLastInput},
              {1'b1, prevData, prevLast});
      compInputReady = ($urandom_range(99, 0) < readyPct);
      if (holdCnt > 0) begin
        holdCnt--;
        outByteReady = 0;
        if (holdCnt == 0) begin
          holdEndReady = compOutputReady; holdEndValid = outByteValid;
          holdEndByte = outByte; holdSeen = 1;
        end
      end else begin
        outByteReady = ($urandom_range(99, 0) < outReadyPct);
      end
      compOutputValid = (bitQ.size() != 0);
      compOutputBit = compOutputValid ? bitQ[0] : 1'b0;
      compDone = modelActive && inputDone && !compOutputValid && !neverDone;
      if (compDone) compBusy = 0;
      if (compDone && !doneCaptured) begin
        doneCaptured = 1;
        cycAtDone = cyc;
      end
      compBytesRead = 32'(consumed.size() + skew);
      // Handshakes that will complete on the coming rising edge.
      if (compInputValid && compInputReady) begin
        consumed.push_back(compInputData);
        if (compLastInput != (consumed.size() == jobLen)) lastErr++;
        if (compLastInput) inputDone = 1;
        nb = $urandom_range(bitsMax, 0);
        for (int i = 0; i < nb; i++) begin
          bv = 1'($urandom_range(1, 0));
          bitQ.push_back(bv);
          sentBits.push_back(bv);
        end
      end
      if (compOutputValid && compOutputReady) void'(bitQ.pop_front());
      if (outByteValid && outByteReady) outBytesQ.push_back(outByte);
      prevValid = compInputValid; prevReady = compInputReady;
      prevData = compInputData; prevLast = compLastInput;
    end
  end

  task automatic buildRef();
    logic [7:0] acc;
    int k;
    refBytes.delete();
    acc = '0;
    k = 0;
    foreach (sentBits[i]) begin
      acc[7-k] = sentBits[i];
      k++;
      if (k == 8) begin
        refBytes.push_back(acc);
        acc = '0;
        k = 0;
      end
    end
    if (k > 0) refBytes.push_back(acc);
  endtask

  task automatic setup(input job_t c);
    jobLen = c.len; readyPct = c.readyPct; outReadyPct = c.outReadyPct; holdCnt = c.outHold;
    bitsMax = c.bitsMax; preloadN = c.preloadN; neverDone = c.neverDone; skew = c.skew;
    holdSeen = 0; lastErr = 0; startPulses = 0;
    outBytesQ.delete(); consumed.delete(); sentBits.delete();
    for (int i = 0; i < c.len; i++) mem[AB'(c.base + i)] = c.preset41 ? 8'h41 : 8'($urandom);
  endtask

  task automatic issueCmd(input logic [AB-1:0] b, input int len);
    @(negedge clk);
    cmdValid = 1; cmdBase = b; cmdLength = LB'(len);
    @(negedge clk);
    cmdValid = 0;
  endtask

  task automatic runJob(input string tag, input job_t c);
    int mism;
    logic [31:0] sBits, sCycles;
    logic sErr;
    setup(c);
    check({tag, ".cmdReady"}, cmdReady, 1);
    issueCmd(c.base, c.len);
    for (int i = 0; i < 40000 && !statusValid; i++) @(negedge clk);
    check({tag, ".statusSeen"}, statusValid, 1);
    sBits = statusBits; sCycles = statusCycles; sErr = statusError;
    outReadyPct = 100;
    for (int i = 0; i < 300 && outByteValid; i++) @(negedge clk);
    check({tag, ".outDrained"}, outByteValid, 0);
    check({tag, ".starts"}, startPulses, 1);
    check({tag, ".bytesFed"}, consumed.size(), c.len);
    mism = 0;
    foreach (consumed[i]) if (consumed[i] !== mem[AB'(c.base + i)]) mism++;
    check({tag, ".dataOrder"}, mism, 0);
    check({tag, ".lastMark"}, lastErr, 0);
    check({tag, ".error"}, sErr, c.expErr);
    check({tag, ".bits"}, sBits, sentBits.size());
    if (!c.neverDone) check({tag, ".cycles"}, sCycles, cycAtDone);
    buildRef();
    check({tag, ".outCount"}, outBytesQ.size(), refBytes.size());
    mism = 0;
    foreach (refBytes[i]) if (i >= outBytesQ.size() || outBytesQ[i] !== refBytes[i]) mism++;
    check({tag, ".outBytes"}, mism, 0);
    if (c.preset41) begin
      check({tag, ".byte0"}, outBytesQ[0], 8'hAA);
      check({tag, ".byte1"}, outBytesQ[1], 8'h80);
    end
    if (c.outHold > 0) begin
      check({tag, ".holdReady"}, {holdSeen, holdEndReady}, 2'b10);
      check({tag, ".holdValid"}, holdEndValid, 1);
      check({tag, ".holdByte"}, holdEndByte, refBytes[0]);
    end
  endtask

  job_t jobs[6];
  job_t rj;
  int k;

  initial begin
    cmdValid = 0; cmdBase = '0; cmdLength = '0; memReadData = '0; compBusy = 0; compDone = 0;
    compInputReady = 0; compOutputBit = 0; compOutputValid = 0; compBytesRead = '0;
    outByteReady = 0; rdPending = 0; prevValid = 0; holdCnt = 0; neverDone = 0;
    repeat (3) @(negedge clk);
    check("rst.cmdReady", cmdReady, 1);
    check("rst.outputs", {memReadEn, compStart, compInputValid, compLastInput, outByteValid,
                          statusValid, statusError, compOutputReady}, 8'h00);
    check("rst.values", {memAddr, compInputData, outByte, statusBits, statusCycles}, '0);
    rst_n = 1;

    //            base      len  rdy  out hold bits pre never skew err p41
    jobs[0] = '{18'h00100,    1, 100, 100,  0,  0,  9, 0,   0,  0,  1};
    jobs[1] = '{18'h02000, 1000,  50,  70,  0,  6,  0, 0,   0,  0,  0};
    jobs[2] = '{18'h00300,   40, 100, 100, 50,  5, 12, 0,   0,  0,  0};
    jobs[3] = '{18'h3FFFE,    4,  80,  60,  0,  9,  0, 0,   0,  0,  0};
    jobs[4] = '{18'h00500,    5, 100, 100,  0,  3,  0, 0,   1,  1,  0};
    jobs[5] = '{18'h00600,   16,  30,  30,  0,  8,  0, 0,   0,  0,  0};
    foreach (jobs[i]) runJob($sformatf("job%0d", i), jobs[i]);

    // Zero length: no start, status two cycles after the command.
    rj = '{18'h0, 0, 100, 100, 0, 0, 0, 0, 0, 1, 0};
    setup(rj);
    issueCmd(18'h00777, 0);
    check("len0.early", {statusValid, cmdReady}, 2'b00);
    @(negedge clk);
    check("len0.status", {statusValid, statusError}, 2'b11);
    check("len0.noStart", startPulses, 0);

    // Watchdog: REPORT WD cycles after START, statusValid the cycle after.
    rj = '{18'h00900, 3, 100, 100, 0, 2, 0, 1, 0, 1, 0};
    setup(rj);
    issueCmd(rj.base, rj.len);
    for (int i = 0; i < 10 && !compStart; i++) @(negedge clk);
    check("wd.start", compStart, 1);
    k = 0;
    while (!statusValid && k < WD + 50) begin
      @(negedge clk);
      k++;
    end
    check("wd.latency", k, WD + 1);
    check("wd.error", statusError, 1);
    check("wd.cycles", statusCycles, WD);
    check("wd.idle", {cmdReady, compInputValid}, 2'b10);
    neverDone = 0;

    // Asynchronous reset in the middle of FEED.
    rj = '{18'h01000, 200, 50, 100, 0, 4, 0, 0, 0, 0, 0};
    setup(rj);
    issueCmd(rj.base, rj.len);
    for (int i = 0; i < 50 && !compInputValid; i++) @(negedge clk);
    check("rstmid.inFeed", compInputValid, 1);
    #2 rst_n = 0;
    #1;
    check("rstmid.cmdReady", cmdReady, 1);
    check("rstmid.outputs", {memReadEn, compStart, compInputValid, compLastInput, outByteValid,
                             statusValid, compOutputReady, compInputData}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    runJob("afterRst", '{18'h02400, 4, 100, 100, 0, 5, 0, 0, 0, 0, 0});

    for (int i = 0; i < 4; i++) begin
      rj = '{AB'($urandom), int'($urandom_range(60, 1)), int'($urandom_range(100, 20)),
             int'($urandom_range(100, 20)), 0, int'($urandom_range(10, 0)), 0, 0, 0, 0, 0};
      runJob($sformatf("rand%0d", i), rj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
